// File: rtl/sine_voice_mixer.sv
// Mixes NUM_VOICES phase-accumulator lanes into one sample per tick through a single
// time-shared sine ROM: snapshot, scan voices in order, drain the ROM, register outputs.
module sine_voice_mixer #(
  parameter int NUM_VOICES = 8,
  parameter int PHASE_W    = 32,
  parameter int LUT_ADDR_W = 8,
  parameter int OUT_SHIFT  = 5
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      sample_tick_in,
  input  logic [NUM_VOICES-1:0]     gate_in,
  input  logic [PHASE_W-1:0]        phase_in [NUM_VOICES],
  output logic signed [15:0]        sample_out,
  output logic [7:0]                audio_out,
  output logic [3:0]                active_count_out,
  output logic                      sample_valid_out,
  output logic                      busy_out,
  output logic                      overrun_out
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int ACC_W = $clog2(NUM_VOICES * 127 + 1) + 1;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, OUTPUT} state_e;

  // First quarter wave (k = 0..64) of round(127*sin(2*pi*k/256)); the rest follows by symmetry.
  localparam logic [6:0] QTR [65] = '{
    7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,  7'd25,  7'd28,
    7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,  7'd49,  7'd51,  7'd54,  7'd57,
    7'd60,  7'd63,  7'd65,  7'd68,  7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,
    7'd85,  7'd88,  7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
    7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116, 7'd117, 7'd118,
    7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124, 7'd125, 7'd125, 7'd126, 7'd126,
    7'd126, 7'd127, 7'd127, 7'd127, 7'd127
  };

  function automatic logic signed [7:0] sine_lut(input logic [7:0] a);
    logic [6:0] h, qi;
    logic [7:0] mag;
    h   = a[6:0];
    qi  = (h > 7'd64) ? 7'(8'd128 - {1'b0, h}) : h;
    mag = {1'b0, QTR[qi]};
    return a[7] ? -mag : mag;
  endfunction

  state_e                  state_q, state_d;
  logic [NUM_VOICES-1:0]   gate_snap_q;
  logic [LUT_ADDR_W-1:0]   addr_snap_q [NUM_VOICES];
  logic [IDX_W-1:0]        idx_q;
  logic signed [7:0]       rom_q;
  logic                    rd_vld_q, rd_gate_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [3:0]              cnt_q;
  logic signed [15:0]      sample_q;
  logic [7:0]              audio_q;
  logic [3:0]              count_q;
  logic                    valid_q, overrun_q;

  logic                    tick_ok;
  logic signed [ACC_W-1:0] rom_ext, acc_div;
  logic signed [15:0]      acc_ext, sample_d;
  logic [7:0]              audio_d;

  // A tick is taken in IDLE and also on the OUTPUT edge so ticks can run back to back.
  assign tick_ok  = sample_tick_in && (state_q == IDLE || state_q == OUTPUT);
  assign rom_ext  = {{(ACC_W-8){rom_q[7]}}, rom_q};
  assign acc_ext  = {{(16-ACC_W){acc_q[ACC_W-1]}}, acc_q};
  assign sample_d = acc_ext <<< OUT_SHIFT;
  assign acc_div  = acc_q >>> 3;
  assign audio_d  = 8'(acc_div + ACC_W'(128));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sample_tick_in) state_d = SCAN;
      SCAN:    if (idx_q == IDX_W'(NUM_VOICES-1)) state_d = DRAIN;
      DRAIN:   state_d = OUTPUT;
      OUTPUT:  state_d = sample_tick_in ? SCAN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_out = (state_q == SCAN) || (state_q == DRAIN);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      gate_snap_q <= '0;
      for (int i = 0; i < NUM_VOICES; i++) addr_snap_q[i] <= '0;
      idx_q     <= '0;
      rom_q     <= '0;
      rd_vld_q  <= 1'b0;
      rd_gate_q <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      sample_q  <= '0;
      audio_q   <= 8'd128;
      count_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      // ROM read issued for voice idx_q; its data and gate are consumed one edge later.
      rd_vld_q  <= (state_q == SCAN);
      rd_gate_q <= gate_snap_q[idx_q];
      rom_q     <= sine_lut(addr_snap_q[idx_q]);
      if (state_q == SCAN) idx_q <= idx_q + IDX_W'(1);
      if (tick_ok) begin
        gate_snap_q <= gate_in;
        for (int i = 0; i < NUM_VOICES; i++)
          addr_snap_q[i] <= phase_in[i][PHASE_W-1 -: LUT_ADDR_W];
        acc_q <= '0;
        cnt_q <= '0;
        idx_q <= '0;
      end else if (rd_vld_q && rd_gate_q) begin
        acc_q <= acc_q + rom_ext;
        cnt_q <= cnt_q + 4'd1;
      end
      if (state_q == OUTPUT) begin
        sample_q <= sample_d;
        audio_q  <= audio_d;
        count_q  <= cnt_q;
        valid_q  <= 1'b1;
      end
      if (sample_tick_in && busy_out) overrun_q <= 1'b1;
    end
  end

  assign sample_out       = sample_q;
  assign audio_out        = audio_q;
  assign active_count_out = count_q;
  assign sample_valid_out = valid_q;
  assign overrun_out      = overrun_q;

endmodule

// File: tb/tb_sine_voice_mixer.sv
// Randomized and directed checks of sine_voice_mixer against a real-arithmetic mixing model.
module tb_sine_voice_mixer;
  localparam int NV = 8;

  logic              clk_in = 1'b0, rst_n_in = 1'b1, sample_tick_in = 1'b0;
  logic [NV-1:0]     gate_in = '0;
  logic [31:0]       phase_in [NV];
  logic signed [15:0] sample_out;
  logic [7:0]        audio_out;
  logic [3:0]        active_count_out;
  logic              sample_valid_out, busy_out, overrun_out;

  int vectors = 0, miscompares = 0;

  sine_voice_mixer dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .sample_tick_in(sample_tick_in),
    .gate_in(gate_in), .phase_in(phase_in),
    .sample_out(sample_out), .audio_out(audio_out), .active_count_out(active_count_out),
    .sample_valid_out(sample_valid_out), .busy_out(busy_out), .overrun_out(overrun_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic int sine_ref(input int k);
    real v;
    v = 127.0 * $sin(2.0 * 3.14159265358979 * k / 256.0);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  function automatic int sum_ref(input logic [NV-1:0] g);
    int s = 0;
    for (int i = 0; i < NV; i++) if (g[i]) s += sine_ref(int'(phase_in[i] / 32'h0100_0000));
    return s;
  endfunction

  function automatic int audio_ref(input int s);
    return ((s >= 0) ? s / 8 : -((-s + 7) / 8)) + 128;
  endfunction

  // Drives one tick and watches 14 edges; lat = edge offset of the first valid pulse (-1 if none).
  task automatic mix(output int lat, output int npulse, output int s, output int a,
                     output int c, output logic [15:0] bm);
    lat = -1; npulse = 0; s = 0; a = 0; c = 0; bm = '0;
    @(negedge clk_in); sample_tick_in = 1'b1;
    @(posedge clk_in); #1 sample_tick_in = 1'b0;
    for (int n = 1; n <= 14; n++) begin
      @(posedge clk_in); #1;
      bm[n] = busy_out;
      if (sample_valid_out) begin
        npulse++;
        if (lat < 0) begin lat = n; s = sample_out; a = audio_out; c = active_count_out; end
      end
    end
  endtask

  task automatic test_reset;
    #2 rst_n_in = 1'b0;
    #1;
    vectors += 4;
    if (sample_out !== 16'sd0) begin miscompares++; $display("FAIL reset_sample got %0d want 0", sample_out); end
    if (audio_out !== 8'd128) begin miscompares++; $display("FAIL reset_audio got %0d want 128", audio_out); end
    if ({active_count_out, sample_valid_out, busy_out, overrun_out} !== 7'd0) begin
      miscompares++; $display("FAIL reset_flags got %b want 0", {active_count_out, sample_valid_out, busy_out, overrun_out});
    end
    repeat (2) @(posedge clk_in);
    @(negedge clk_in) rst_n_in = 1'b1;
    #1 if (busy_out !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy_out); end
  endtask

  task automatic test_single_voice;
    int lat, np, s, a, c, e; logic [15:0] bm;
    for (int i = 0; i < NV; i++) phase_in[i] = $urandom;
    phase_in[0] = 32'h4000_0000; gate_in = 8'h01;
    e = sum_ref(gate_in);
    mix(lat, np, s, a, c, bm);
    vectors += 7;
    if (lat !== 10) begin miscompares++; $display("FAIL single_latency got %0d want 10", lat); end
    if (np !== 1) begin miscompares++; $display("FAIL single_pulses got %0d want 1", np); end
    if (s !== e * 32 || s !== 4064) begin miscompares++; $display("FAIL single_sample got %0d want %0d", s, e * 32); end
    if (a !== audio_ref(e)) begin miscompares++; $display("FAIL single_audio got %0d want %0d", a, audio_ref(e)); end
    if (c !== 1) begin miscompares++; $display("FAIL single_count got %0d want 1", c); end
    if (bm[8:1] !== 8'hFF) begin miscompares++; $display("FAIL single_busy_high got %b want 11111111", bm[8:1]); end
    if (bm[10] !== 1'b0) begin miscompares++; $display("FAIL single_busy_low got %b want 0", bm[10]); end
  endtask

  task automatic test_full_chord;
    int lat, np, s, a, c, e; logic [15:0] bm;
    for (int i = 0; i < NV; i++) phase_in[i] = 32'h4000_0000;
    gate_in = 8'hFF;
    e = sum_ref(gate_in);
    mix(lat, np, s, a, c, bm);
    vectors += 3;
    if (s !== e * 32) begin miscompares++; $display("FAIL chord_sample got %0d want %0d", s, e * 32); end
    if (a !== audio_ref(e)) begin miscompares++; $display("FAIL chord_audio got %0d want %0d", a, audio_ref(e)); end
    if (c !== 8) begin miscompares++; $display("FAIL chord_count got %0d want 8", c); end
  endtask

  task automatic test_cancel_mask;
    int lat, np, s, a, c, e; logic [15:0] bm;
    logic [NV-1:0] gates [3] = '{8'h03, 8'h01, 8'h02};
    logic [31:0]   ph0   [3] = '{32'h4000_0000, 32'h0, 32'h4000_0000};
    logic [31:0]   ph1   [3] = '{32'hC000_0000, 32'h4000_0000, 32'hC000_0000};
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < NV; i++) phase_in[i] = $urandom;
      phase_in[0] = ph0[t]; phase_in[1] = ph1[t]; gate_in = gates[t];
      e = sum_ref(gate_in);
      mix(lat, np, s, a, c, bm);
      vectors += 3;
      if (s !== e * 32) begin miscompares++; $display("FAIL mask%0d_sample got %0d want %0d", t, s, e * 32); end
      if (a !== audio_ref(e)) begin miscompares++; $display("FAIL mask%0d_audio got %0d want %0d", t, a, audio_ref(e)); end
      if (c !== $countones(gates[t])) begin miscompares++; $display("FAIL mask%0d_count got %0d want %0d", t, c, $countones(gates[t])); end
    end
  endtask

  task automatic test_snapshot_overrun;
    int e, np, lat, s;
    for (int i = 0; i < NV; i++) phase_in[i] = $urandom;
    phase_in[0] = 32'h4000_0000; gate_in = 8'h01;
    e = sum_ref(gate_in);
    np = 0; lat = -1; s = 0;
    @(negedge clk_in); sample_tick_in = 1'b1;
    @(posedge clk_in); #1 sample_tick_in = 1'b0;
    for (int n = 1; n <= 14; n++) begin
      @(posedge clk_in); #1;
      if (n == 1) begin phase_in[0] = 32'hC000_0000; gate_in = 8'hFF; end
      if (n == 2) sample_tick_in = 1'b1;
      if (n == 3) sample_tick_in = 1'b0;
      if (sample_valid_out) begin np++; if (lat < 0) begin lat = n; s = sample_out; end end
    end
    vectors += 4;
    if (np !== 1) begin miscompares++; $display("FAIL overrun_pulses got %0d want 1", np); end
    if (lat !== 10) begin miscompares++; $display("FAIL overrun_latency got %0d want 10", lat); end
    if (s !== e * 32) begin miscompares++; $display("FAIL snapshot_sample got %0d want %0d", s, e * 32); end
    if (overrun_out !== 1'b1) begin miscompares++; $display("FAIL overrun_flag got %b want 1", overrun_out); end
    repeat (5) @(posedge clk_in);
    #1 vectors++;
    if (overrun_out !== 1'b1) begin miscompares++; $display("FAIL overrun_held got %b want 1", overrun_out); end
  endtask

  task automatic test_back_to_back;
    int e1, e2, lat2, s2, a2;
    for (int i = 0; i < NV; i++) phase_in[i] = $urandom;
    phase_in[0] = 32'h4000_0000; gate_in = 8'h01;
    e1 = sum_ref(gate_in);
    @(negedge clk_in); sample_tick_in = 1'b1;
    @(posedge clk_in); #1 sample_tick_in = 1'b0;
    for (int n = 1; n <= 9; n++) begin @(posedge clk_in); #1; end
    phase_in[1] = 32'hC000_0000; gate_in = 8'h02; sample_tick_in = 1'b1;
    e2 = sum_ref(gate_in);
    @(posedge clk_in); #1 sample_tick_in = 1'b0;
    vectors += 2;
    if (sample_valid_out !== 1'b1) begin miscompares++; $display("FAIL b2b_first_valid got %b want 1", sample_valid_out); end
    if (sample_out !== 16'(e1 * 32)) begin miscompares++; $display("FAIL b2b_first_sample got %0d want %0d", sample_out, e1 * 32); end
    lat2 = -1; s2 = 0; a2 = 0;
    for (int n = 11; n <= 24; n++) begin
      @(posedge clk_in); #1;
      if (sample_valid_out && lat2 < 0) begin lat2 = n; s2 = sample_out; a2 = audio_out; end
    end
    vectors += 3;
    if (lat2 !== 20) begin miscompares++; $display("FAIL b2b_second_latency got %0d want 20", lat2); end
    if (s2 !== e2 * 32) begin miscompares++; $display("FAIL b2b_second_sample got %0d want %0d", s2, e2 * 32); end
    if (a2 !== audio_ref(e2)) begin miscompares++; $display("FAIL b2b_second_audio got %0d want %0d", a2, audio_ref(e2)); end
  endtask

  task automatic test_reset_mid_scan;
    int lat, np, s, a, c, e, seen; logic [15:0] bm;
    for (int i = 0; i < NV; i++) phase_in[i] = 32'h4000_0000;
    gate_in = 8'hFF;
    mix(lat, np, s, a, c, bm);
    @(negedge clk_in); sample_tick_in = 1'b1;
    @(posedge clk_in); #1 sample_tick_in = 1'b0;
    repeat (5) @(posedge clk_in);
    #1 rst_n_in = 1'b0;
    #1;
    vectors += 3;
    if (sample_out !== 16'sd0 || audio_out !== 8'd128) begin
      miscompares++; $display("FAIL midreset_outputs got %0d/%0d want 0/128", sample_out, audio_out);
    end
    if (active_count_out !== 4'd0) begin miscompares++; $display("FAIL midreset_count got %0d want 0", active_count_out); end
    if ({busy_out, overrun_out} !== 2'b00) begin miscompares++; $display("FAIL midreset_flags got %b want 00", {busy_out, overrun_out}); end
    repeat (2) @(posedge clk_in);
    @(negedge clk_in) rst_n_in = 1'b1;
    seen = 0;
    for (int n = 0; n < 12; n++) begin @(posedge clk_in); #1; if (sample_valid_out) seen++; end
    vectors++;
    if (seen !== 0) begin miscompares++; $display("FAIL midreset_no_pulse got %0d want 0", seen); end
    gate_in = 8'h05;
    e = sum_ref(gate_in);
    mix(lat, np, s, a, c, bm);
    vectors += 2;
    if (lat !== 10) begin miscompares++; $display("FAIL midreset_next_latency got %0d want 10", lat); end
    if (s !== e * 32) begin miscompares++; $display("FAIL midreset_next_sample got %0d want %0d", s, e * 32); end
  endtask

  task automatic test_random;
    int lat, np, s, a, c, e; logic [15:0] bm;
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < NV; i++) phase_in[i] = $urandom;
      gate_in = NV'($urandom);
      e = sum_ref(gate_in);
      mix(lat, np, s, a, c, bm);
      vectors += 4;
      if (lat !== 10) begin miscompares++; $display("FAIL rand%0d_latency got %0d want 10", t, lat); end
      if (s !== e * 32) begin miscompares++; $display("FAIL rand%0d_sample got %0d want %0d", t, s, e * 32); end
      if (a !== audio_ref(e)) begin miscompares++; $display("FAIL rand%0d_audio got %0d want %0d", t, a, audio_ref(e)); end
      if (c !== $countones(gate_in)) begin miscompares++; $display("FAIL rand%0d_count got %0d want %0d", t, c, $countones(gate_in)); end
    end
  endtask

  initial begin
    for (int i = 0; i < NV; i++) phase_in[i] = '0;
    test_reset;
    test_single_voice;
    test_full_chord;
    test_cancel_mask;
    test_snapshot_overrun;
    test_back_to_back;
    test_reset_mid_scan;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
